rca_nibble_seq: RTL



---
 rtl/rca_nibble_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rca_nibble_seq.sv
`default_nettype none
// ============================================================================
// Module   : rca_nibble_seq (with 4-bit ripple-carry slice rca)
// Brief    : Wide adder that streams one nibble per clock through a single rca.
// Revision : 1.0 - initial release
// ============================================================================

module rca (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);
    logic [4:0] w_c;

    assign w_c[0] = i_c;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fa
            assign o_s[gi]    = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_c = w_c[4];
endmodule

module rca_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             busy_o
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] c_LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cy;
    logic              r_carry_out;
    logic              r_ovf;
    logic [IDXW-1:0]   r_idx;

    logic [3:0]        w_a_sl;
    logic [3:0]        w_b_sl;
    logic [3:0]        w_s_sl;
    logic              w_c_sl;
    logic [WIDTH-1:0]  w_sum_nxt;
    logic              w_last;

    // Operand slice mux and result slice merge are kept in separate blocks
    // so the path through the rca instance is not seen as a feedback loop.
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_sl = r_a[4*i +: 4];
                w_b_sl = r_b[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_sum_nxt = r_sum;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_sum_nxt[4*i +: 4] = w_s_sl;
            end
        end
    end

    rca u_rca (
        .i_a (w_a_sl),
        .i_b (w_b_sl),
        .i_c (r_cy),
        .o_s (w_s_sl),
        .o_c (w_c_sl)
    );

    assign w_last = (r_idx == c_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid_i)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)      w_state_nxt = S_DONE;
            S_DONE:  if (out_ready_i) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cy        <= 1'b0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_a         <= a_i;
                        r_b         <= b_i;
                        r_cy        <= carry_i;
                        r_idx       <= '0;
                        r_sum       <= '0;
                        r_carry_out <= 1'b0;
                        r_ovf       <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_sum <= w_sum_nxt;
                    r_cy  <= w_c_sl;
                    if (w_last) begin
                        r_carry_out <= w_c_sl;
                        // Top-nibble sum bit is only now known, so take it from the slice.
                        r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s_sl[3] != r_a[WIDTH-1]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign busy_o      = (r_state != S_IDLE);
    assign sum_o       = r_sum;
    assign carry_o     = r_carry_out;
    assign ovf_o       = r_ovf;
endmodule

`default_nettype wire
